// File: rtl/cpu_stepper.sv
// Six-step sequencer for the 7-step CPU: one-hot step pulses, instruction latch and
// jump-if evaluation that drive the data-bus routing, plus run/step/halt control.
module cpu_stepper #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_step_once,
    input  logic [0:7]       i_ir,
    input  logic [0:3]       i_flags,
    output logic [1:6]       o_step,
    output logic [0:3]       o_instr,
    output logic             o_ir_io,
    output logic             o_flags_detected,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_instr_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_S6
    } state_t;

    state_t           state_q, state_d;
    logic             single_q, single_d;
    logic [1:6]       step_q, step_d;
    logic             busy_q, busy_d;
    logic [0:3]       instr_q;
    logic             ir_io_q;
    logic             flags_det_q;
    logic [CNT_W-1:0] cnt_q;
    logic             latch_en;
    logic             instr_done;
    logic             jump_hit;

    always_comb begin
        state_d  = state_q;
        single_d = single_q;
        case (state_q)
            ST_IDLE: begin
                if (i_run) begin
                    state_d = ST_S1;
                end else if (i_step_once) begin
                    state_d  = ST_S1;
                    single_d = 1'b1;
                end
            end
            ST_S1: state_d = ST_S2;
            ST_S2: state_d = ST_S3;
            ST_S3: state_d = ST_S4;
            ST_S4: state_d = ST_S5;
            ST_S5: state_d = ST_S6;
            ST_S6: begin
                if (i_run && !single_q) begin
                    state_d = ST_S1;
                end else begin
                    state_d  = ST_IDLE;
                    single_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                single_d = 1'b0;
            end
        endcase
    end

    // Step pulses are decoded from the next state so they register alongside it.
    always_comb begin
        step_d = 6'b00_0000;
        case (state_d)
            ST_S1:   step_d = 6'b10_0000;
            ST_S2:   step_d = 6'b01_0000;
            ST_S3:   step_d = 6'b00_1000;
            ST_S4:   step_d = 6'b00_0100;
            ST_S5:   step_d = 6'b00_0010;
            ST_S6:   step_d = 6'b00_0001;
            default: step_d = 6'b00_0000;
        endcase
        busy_d = |step_d;
    end

    // IR is loaded during S2 and flags reflect the previous instruction, so both are
    // sampled only on the S3->S4 edge.
    assign latch_en   = (state_q == ST_S3);
    assign instr_done = (state_q == ST_S6);
    assign jump_hit   = (i_ir[0:3] == 4'b0101) && (|(i_ir[4:7] & i_flags));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            single_q    <= 1'b0;
            step_q      <= 6'b00_0000;
            busy_q      <= 1'b0;
            instr_q     <= 4'b0000;
            ir_io_q     <= 1'b0;
            flags_det_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            if (latch_en) begin
                instr_q     <= i_ir[0:3];
                ir_io_q     <= i_ir[4];
                flags_det_q <= jump_hit;
            end
            if (instr_done) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_step           = step_q;
    assign o_busy           = busy_q;
    assign o_instr          = instr_q;
    assign o_ir_io          = ir_io_q;
    assign o_flags_detected = flags_det_q;
    assign o_instr_cnt      = cnt_q;

endmodule

// File: doc/cpu_stepper.md
# cpu_stepper

Sequencing engine for the 7-step CPU: it generates the one-hot `step` pulses, latches the current instruction from the IR, and derives `instr`, `ir_io` and `flags_detected`. Those four signals are exactly the routing-control inputs that `data_bus` consumes. The block is the driving end of the data-bus control interface. It also provides run/halt, single-instruction stepping and an executed-instruction counter for debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the executed-instruction counter.

Ports:
- `i_clk`  in  1  system clock; all state changes on the rising edge.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_run`  in  1  level; high = free-run instructions back to back.
- `i_step_once`  in  1  one-cycle pulse; execute exactly one instruction from idle.
- `i_ir`  in  [0:7]  IR contents. Bits [0:3] are the opcode. Bits [4:7] are the io direction / jump-if flag mask.
- `i_flags`  in  [0:3]  flag register, ordered C, A(larger), E(qual), Z(ero).
- `o_step`  out  [1:6]  one-hot step; all zero when idle.
- `o_instr`  out  [0:3]  latched opcode.
- `o_ir_io`  out  1  latched `i_ir[4]` (0 = input, 1 = output), valid for opcode 0111.
- `o_flags_detected`  out  1  jump-if condition met.
- `o_busy`  out  1  high in any step state.
- `o_instr_cnt`  out  [CNT_W-1:0]  count of completed instructions.

## Operation
- State machine: IDLE, S1, S2, S3, S4, S5, S6.
  - `o_step` is 6'b10_0000 in S1 through 6'b00_0001 in S6, and 0 in IDLE.
  - All outputs are registered.
- IDLE transitions:
  - `i_run`=1 goes to S1.
  - Otherwise `i_step_once`=1 goes to S1 and sets an internal `single` flag.
  - Otherwise the state stays IDLE.
- S1→S2→S3→S4→S5→S6 advance unconditionally, one per clock.
- S6 transitions:
  - Go to S1 if `i_run`=1 and `single`=0.
  - Otherwise go to IDLE and clear `single`.
- `i_step_once` is ignored outside IDLE. `i_run` dominates when it is asserted together with `i_step_once`. Dropping `i_run` mid-instruction finishes the current instruction and then goes to IDLE.
- Instruction latch, on the S3→S4 edge only:
  - `o_instr` ← `i_ir[0:3]`.
  - `o_ir_io` ← `i_ir[4]`.
  - `o_flags_detected` ← (`i_ir[0:3]`==4'b0101) & |(`i_ir[4:7]` & `i_flags`).
- The latched values hold through S4–S6, the following fetch S1–S3 and IDLE, until the next S3→S4 edge.
- Opcode decode is fixed and is not interpreted further here:
  - 1xxx ALU.
  - 0000 load, 0001 store, 0010 data, 0011 jmpr, 0100 jmp, 0101 jmp-if, 0110 clf, 0111 io.
- `o_instr_cnt` increments by 1 on every S6 exit. It wraps from all-ones to 0.
- Synchronous reset, in any state, applies on the next edge with `i_rst_n`=0:
  - state=IDLE, `single`=0, `o_step`=0, `o_instr`=0, `o_ir_io`=0, `o_flags_detected`=0, `o_busy`=0, `o_instr_cnt`=0.
- Reset mid-instruction abandons that instruction. It is not counted.

## Timing
- Start latency: `i_run` or `i_step_once` sampled high in IDLE gives `o_step`=S1 on the next edge.
- An instruction is exactly 6 cycles. Back-to-back instructions have no gap, going from S6 directly to S1.
- `i_ir` and `i_flags` are sampled only on the S3→S4 edge. They must be stable in the S3 cycle: IR is set in S2, and flags come from the previous instruction.
- `o_instr`, `o_ir_io` and `o_flags_detected` are valid from the first S4 cycle.
- `o_busy` = |`o_step`, registered together with the state.
- The count update is visible in the cycle after S6, i.e. in S1 or IDLE.

## Test plan
- Reset behaviour: assert `i_rst_n`=0 while in S4 with `o_instr_cnt`=5. The next cycle shows IDLE, all outputs 0. Hold `i_run`=1 and release reset; S1 appears 1 cycle later.
- Free run: `i_run`=1, `i_ir`=8'h80 (ALU add). The step sequence is 10_0000…00_0001 repeating with no gap. `o_instr`=4'b1000 from S4. The count increments every 6 cycles.
- Single step: `i_step_once` pulse with `i_ir`=8'h72 (io, output bit 0). Exactly one S1–S6 pass, then IDLE. `o_instr`=0111, `o_ir_io`=0, count +1. A second pulse given mid-instruction is ignored.
- Jump-if evaluation, with `i_ir`=8'h52 (mask E):
  - `i_flags`=4'b0010 gives `o_flags_detected`=1.
  - `i_flags`=4'b1101 gives 0.
  - Opcode 0100 with `i_flags`=4'b1111 gives 0.
- Halt mid-instruction: drop `i_run` during S2. S3–S6 complete, then IDLE with `o_step`=0. The latched `o_instr` is held.
- Wrap: `CNT_W`=4, run 17 instructions. `o_instr_cnt` wraps from 15 to 0 and ends at 1.
